// File: rtl/down_counter_6bit.sv
// 6-bit loadable down counter with IDLE/RUN/DONE control and manual single-step decrement.
// Define DOWN_COUNTER_SATURATE_EN to make a manual decrement at zero saturate instead of wrapping to 63.
module down_counter_6bit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [5:0] start_val,
   input  logic       hold,
   input  logic       dec,
   output logic [5:0] count,
   output logic       busy,
   output logic       done,
   output logic       zero,
   output logic       borrow
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

`ifdef DOWN_COUNTER_SATURATE_EN
   localparam logic [5:0] UNDERFLOW_VAL = 6'd0;
`else
   localparam logic [5:0] UNDERFLOW_VAL = 6'd63;
`endif

   state_t     state_q, state_d;
   logic [5:0] count_q, count_d;
   logic       borrow_q, borrow_d;

   function automatic logic [5:0] dec6(input logic [5:0] v);
      return v - 6'd1;
   endfunction

   // next-state and next-count decode
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      borrow_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               count_d = start_val;
               state_d = ST_RUN;
            end else if (dec) begin
               if (count_q != 6'd0) begin
                  count_d = dec6(count_q);
               end else begin
                  count_d  = UNDERFLOW_VAL;
                  borrow_d = 1'b1;
               end
            end else begin
               count_d = count_q;
            end
         end
         ST_RUN: begin
            // a zero start value still spends one cycle in RUN before DONE
            if (hold) begin
               count_d = count_q;
            end else if (count_q <= 6'd1) begin
               count_d = 6'd0;
               state_d = ST_DONE;
            end else begin
               count_d = dec6(count_q);
            end
         end
         ST_DONE: begin
            count_d = 6'd0;
            state_d = ST_IDLE;
         end
         default: begin
            count_d = 6'd0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // state, count and borrow registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         count_q  <= 6'd0;
         borrow_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         borrow_q <= borrow_d;
      end
   end

   assign count  = count_q;
   assign busy   = (state_q == ST_RUN);
   assign done   = (state_q == ST_DONE);
   assign zero   = (count_q == 6'd0);
   assign borrow = borrow_q;

endmodule

// File: tb/tb_down_counter_6bit.sv
// Directed self-checking bench for down_counter_6bit; follows DOWN_COUNTER_SATURATE_EN like the design.
module tb_down_counter_6bit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic [5:0] start_val = 6'd0;
   logic       hold = 1'b0;
   logic       dec = 1'b0;
   logic [5:0] count;
   logic       busy, done, zero, borrow;

   int total_cnt = 0;
   int pass_cnt  = 0;

   down_counter_6bit dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_val(start_val),
      .hold(hold), .dec(dec), .count(count), .busy(busy), .done(done),
      .zero(zero), .borrow(borrow)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] pk(input logic [5:0] c, input logic b, input logic d,
                                     input logic z, input logic br);
      return {c, b, d, z, br};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({count, busy, done, zero, borrow} !== pk(6'd0, 1'b0, 1'b0, 1'b1, 1'b0))
         $display("FAIL reset_async: got count=%0d busy=%b done=%b zero=%b borrow=%b, expected 0/0/0/1/0",
                  count, busy, done, zero, borrow);
      else pass_cnt++;
      for (int i = 0; i < 2; i++) begin
         step();
         total_cnt++;
         if ({count, busy, done, zero, borrow} !== pk(6'd0, 1'b0, 1'b0, 1'b1, 1'b0))
            $display("FAIL reset_hold[%0d]: got count=%0d busy=%b done=%b zero=%b borrow=%b, expected 0/0/0/1/0",
                     i, count, busy, done, zero, borrow);
         else pass_cnt++;
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_count3();
      logic [9:0] exp_q[$];
      exp_q = '{pk(6'd3,1'b1,1'b0,1'b0,1'b0), pk(6'd2,1'b1,1'b0,1'b0,1'b0), pk(6'd1,1'b1,1'b0,1'b0,1'b0),
                pk(6'd0,1'b0,1'b1,1'b1,1'b0), pk(6'd0,1'b0,1'b0,1'b1,1'b0)};
      for (int i = 0; i < exp_q.size(); i++) begin
         start = (i == 0); start_val = 6'd3;
         step();
         total_cnt++;
         if ({count, busy, done, zero, borrow} !== exp_q[i])
            $display("FAIL count3[E%0d]: got count=%0d busy=%b done=%b zero=%b borrow=%b, expected %b",
                     i, count, busy, done, zero, borrow, exp_q[i]);
         else pass_cnt++;
      end
      start = 1'b0;
   endtask

   task automatic test_zero_start();
      logic [9:0] exp_q[$];
      exp_q = '{pk(6'd0,1'b1,1'b0,1'b1,1'b0), pk(6'd0,1'b0,1'b1,1'b1,1'b0), pk(6'd0,1'b0,1'b0,1'b1,1'b0)};
      for (int i = 0; i < exp_q.size(); i++) begin
         start = (i == 0); start_val = 6'd0;
         step();
         total_cnt++;
         if ({count, busy, done, zero, borrow} !== exp_q[i])
            $display("FAIL zero_start[E%0d]: got count=%0d busy=%b done=%b zero=%b borrow=%b, expected %b",
                     i, count, busy, done, zero, borrow, exp_q[i]);
         else pass_cnt++;
      end
      start = 1'b0;
   endtask

   task automatic test_hold();
      logic [9:0] exp_q[$];
      exp_q = '{pk(6'd5,1'b1,1'b0,1'b0,1'b0), pk(6'd4,1'b1,1'b0,1'b0,1'b0), pk(6'd3,1'b1,1'b0,1'b0,1'b0),
                pk(6'd3,1'b1,1'b0,1'b0,1'b0), pk(6'd3,1'b1,1'b0,1'b0,1'b0), pk(6'd2,1'b1,1'b0,1'b0,1'b0),
                pk(6'd1,1'b1,1'b0,1'b0,1'b0), pk(6'd0,1'b0,1'b1,1'b1,1'b0), pk(6'd0,1'b0,1'b0,1'b1,1'b0)};
      for (int i = 0; i < exp_q.size(); i++) begin
         start = (i == 0); start_val = 6'd5;
         hold = (i == 3) || (i == 4) || (i == 8);
         step();
         total_cnt++;
         if ({count, busy, done, zero, borrow} !== exp_q[i])
            $display("FAIL hold[E%0d]: got count=%0d busy=%b done=%b zero=%b borrow=%b, expected %b",
                     i, count, busy, done, zero, borrow, exp_q[i]);
         else pass_cnt++;
      end
      start = 1'b0; hold = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [9:0] exp_q[$];
      exp_q = '{pk(6'd1,1'b1,1'b0,1'b0,1'b0), pk(6'd0,1'b0,1'b1,1'b1,1'b0), pk(6'd0,1'b0,1'b0,1'b1,1'b0),
                pk(6'd7,1'b1,1'b0,1'b0,1'b0), pk(6'd6,1'b1,1'b0,1'b0,1'b0), pk(6'd5,1'b1,1'b0,1'b0,1'b0),
                pk(6'd4,1'b1,1'b0,1'b0,1'b0), pk(6'd3,1'b1,1'b0,1'b0,1'b0), pk(6'd2,1'b1,1'b0,1'b0,1'b0),
                pk(6'd1,1'b1,1'b0,1'b0,1'b0), pk(6'd0,1'b0,1'b1,1'b1,1'b0), pk(6'd0,1'b0,1'b0,1'b1,1'b0)};
      for (int i = 0; i < exp_q.size(); i++) begin
         // start held through the DONE cycle: dropped at E2, accepted at E3
         start = (i <= 3); start_val = (i == 0) ? 6'd1 : 6'd7;
         dec = (i == 2);
         step();
         total_cnt++;
         if ({count, busy, done, zero, borrow} !== exp_q[i])
            $display("FAIL back_to_back[E%0d]: got count=%0d busy=%b done=%b zero=%b borrow=%b, expected %b",
                     i, count, busy, done, zero, borrow, exp_q[i]);
         else pass_cnt++;
      end
      start = 1'b0; dec = 1'b0;
   endtask

   task automatic test_dec();
      logic [9:0] exp_q[$];
`ifdef DOWN_COUNTER_SATURATE_EN
      exp_q = '{pk(6'd0,1'b0,1'b0,1'b1,1'b1), pk(6'd0,1'b0,1'b0,1'b1,1'b1), pk(6'd0,1'b0,1'b0,1'b1,1'b0),
                pk(6'd0,1'b0,1'b0,1'b1,1'b1), pk(6'd0,1'b0,1'b0,1'b1,1'b0)};
`else
      exp_q = '{pk(6'd63,1'b0,1'b0,1'b0,1'b1), pk(6'd62,1'b0,1'b0,1'b0,1'b0), pk(6'd62,1'b0,1'b0,1'b0,1'b0),
                pk(6'd61,1'b0,1'b0,1'b0,1'b0), pk(6'd61,1'b0,1'b0,1'b0,1'b0)};
`endif
      for (int i = 0; i < exp_q.size(); i++) begin
         dec = (i == 0) || (i == 1) || (i == 3);
         hold = (i == 2);
         step();
         total_cnt++;
         if ({count, busy, done, zero, borrow} !== exp_q[i])
            $display("FAIL dec[E%0d]: got count=%0d busy=%b done=%b zero=%b borrow=%b, expected %b",
                     i, count, busy, done, zero, borrow, exp_q[i]);
         else pass_cnt++;
      end
      dec = 1'b0; hold = 1'b0;
   endtask

   task automatic test_start_dec_priority();
      logic [9:0] exp_q[$];
      exp_q = '{pk(6'd10,1'b1,1'b0,1'b0,1'b0), pk(6'd9,1'b1,1'b0,1'b0,1'b0), pk(6'd8,1'b1,1'b0,1'b0,1'b0),
                pk(6'd7,1'b1,1'b0,1'b0,1'b0), pk(6'd6,1'b1,1'b0,1'b0,1'b0), pk(6'd5,1'b1,1'b0,1'b0,1'b0),
                pk(6'd4,1'b1,1'b0,1'b0,1'b0), pk(6'd3,1'b1,1'b0,1'b0,1'b0), pk(6'd2,1'b1,1'b0,1'b0,1'b0),
                pk(6'd1,1'b1,1'b0,1'b0,1'b0), pk(6'd0,1'b0,1'b1,1'b1,1'b0), pk(6'd0,1'b0,1'b0,1'b1,1'b0)};
      for (int i = 0; i < exp_q.size(); i++) begin
         start = (i <= 2); dec = (i <= 2);
         start_val = (i == 0) ? 6'd10 : 6'd40;
         step();
         total_cnt++;
         if ({count, busy, done, zero, borrow} !== exp_q[i])
            $display("FAIL start_dec_priority[E%0d]: got count=%0d busy=%b done=%b zero=%b borrow=%b, expected %b",
                     i, count, busy, done, zero, borrow, exp_q[i]);
         else pass_cnt++;
      end
      start = 1'b0; dec = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      logic [9:0] exp_q[$];
      for (int i = 0; i <= 8; i++) begin
         start = (i == 0); start_val = 6'd20;
         step();
         total_cnt++;
         if ({count, busy, done, zero, borrow} !== pk(6'd20 - 6'(i), 1'b1, 1'b0, 1'b0, 1'b0))
            $display("FAIL mid_run_count[E%0d]: got count=%0d busy=%b done=%b zero=%b borrow=%b, expected count=%0d busy=1",
                     i, count, busy, done, zero, borrow, 20 - i);
         else pass_cnt++;
      end
      start = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({count, busy, done, zero, borrow} !== pk(6'd0, 1'b0, 1'b0, 1'b1, 1'b0))
         $display("FAIL mid_run_reset: got count=%0d busy=%b done=%b zero=%b borrow=%b, expected 0/0/0/1/0",
                  count, busy, done, zero, borrow);
      else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         step();
         total_cnt++;
         if ({count, busy, done, zero, borrow} !== pk(6'd0, 1'b0, 1'b0, 1'b1, 1'b0))
            $display("FAIL mid_run_in_reset[%0d]: got count=%0d busy=%b done=%b zero=%b borrow=%b, expected 0/0/0/1/0",
                     i, count, busy, done, zero, borrow);
         else pass_cnt++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_q = '{pk(6'd2,1'b1,1'b0,1'b0,1'b0), pk(6'd1,1'b1,1'b0,1'b0,1'b0),
                pk(6'd0,1'b0,1'b1,1'b1,1'b0), pk(6'd0,1'b0,1'b0,1'b1,1'b0)};
      for (int i = 0; i < exp_q.size(); i++) begin
         start = (i == 0); start_val = 6'd2;
         step();
         total_cnt++;
         if ({count, busy, done, zero, borrow} !== exp_q[i])
            $display("FAIL after_reset_run[E%0d]: got count=%0d busy=%b done=%b zero=%b borrow=%b, expected %b",
                     i, count, busy, done, zero, borrow, exp_q[i]);
         else pass_cnt++;
      end
      start = 1'b0;
   endtask

   initial begin
      test_reset();
      test_count3();
      test_zero_start();
      test_hold();
      test_back_to_back();
      test_dec();
      test_start_dec_priority();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
